// File: rtl/enc_pb_scan.sv
// Control-panel input front end: synchronises and debounces encoder and button pins,
// decodes quadrature into saturating signed counts with read-and-clear, and tracks sticky press events.
module enc_pb_scan #(
  parameter int CH      = 8,
  parameter int PB      = 8,
  parameter int CNT_W   = 8,
  parameter int DEB_DIV = 250,
  parameter int DEB_CNT = 4,
  parameter int DETENT  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2*CH-1:0]         enc_i,
  input  logic [PB-1:0]           pb_i,
  input  logic                    rd_i,
  input  logic [3:0]              rd_sel_i,
  output logic signed [CNT_W-1:0] rd_data_o,
  output logic                    rd_vld_o,
  output logic [CH-1:0]           err_o,
  output logic [PB-1:0]           pb_lvl_o,
  output logic [PB-1:0]           pb_evt_o,
  input  logic [PB-1:0]           pb_clr_i
);

  localparam int NB = 2*CH + PB;
  localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic signed [3:0] DET = 4'(DETENT);
  localparam logic signed [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CMIN = {1'b1, {(CNT_W-1){1'b0}}};

  // Gray position along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gpos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  function automatic logic signed [CNT_W-1:0] sat_add(input logic signed [CNT_W-1:0] a,
                                                      input logic signed [1:0] s);
    if (s == 2'sd1 && a == CMAX) return a;
    if (s == -2'sd1 && a == CMIN) return a;
    return a + CNT_W'(s);
  endfunction

  logic [NB-1:0]           sync1_q, sync2_q;
  logic [NB-1:0]           acc_q, acc_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  logic [3:0]              dcnt_q [NB];
  logic [3:0]              dcnt_d [NB];
  logic signed [3:0]       sub_q [CH];
  logic signed [3:0]       sub_d [CH];
  logic signed [CNT_W-1:0] cnt_q [CH];
  logic signed [CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]           err_q, err_d;
  logic [PB-1:0]           pb_evt_q, pb_evt_d;
  logic signed [CNT_W-1:0] rd_data_q, rd_data_d;
  logic                    rd_vld_q, rd_vld_d;

  assign tick    = (presc_q == PW'(DEB_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Debounce: a new level is accepted after DEB_CNT consecutive differing ticks.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NB; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (tick) begin
        if (sync2_q[i] != acc_q[i]) begin
          if (dcnt_q[i] + 4'd1 >= 4'(DEB_CNT)) begin
            acc_d[i]  = sync2_q[i];
            dcnt_d[i] = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 4'd1;
          end
        end else begin
          dcnt_d[i] = '0;
        end
      end
    end
  end

  // Quadrature decode, detent accumulation, saturating count, read-and-clear.
  always_comb begin
    logic [1:0]        dq;
    logic signed [1:0] edg;
    logic signed [1:0] st;
    logic signed [3:0] sn;
    logic              ill;
    logic              hit;
    dq  = '0;
    edg = '0;
    st  = '0;
    sn  = '0;
    ill = 1'b0;
    hit = 1'b0;
    rd_vld_d  = rd_i;
    rd_data_d = rd_data_q;
    if (rd_i) rd_data_d = '0;
    for (int k = 0; k < CH; k++) begin
      dq  = gpos(acc_d[2*k +: 2]) - gpos(acc_q[2*k +: 2]);
      edg = '0;
      ill = 1'b0;
      case (dq)
        2'b01:   edg = 2'sd1;
        2'b11:   edg = -2'sd1;
        2'b10:   ill = 1'b1;
        default: edg = '0;
      endcase
      sn = sub_q[k] + 4'(edg);
      st = '0;
      if (sn == DET) begin
        st = 2'sd1;
        sn = '0;
      end else if (sn == -DET) begin
        st = -2'sd1;
        sn = '0;
      end
      sub_d[k] = sn;
      hit = rd_i && (rd_sel_i == 4'(k));
      if (hit) rd_data_d = cnt_q[k];
      cnt_d[k] = hit ? CNT_W'(st) : sat_add(cnt_q[k], st);
      err_d[k] = ill | (err_q[k] & ~hit);
    end
  end

  // A press is the accepted active-low pin falling; a press in the same cycle as a clear wins.
  assign pb_evt_d = (pb_evt_q & ~pb_clr_i) | (acc_q[2*CH +: PB] & ~acc_d[2*CH +: PB]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      acc_q     <= '1;
      presc_q   <= '0;
      for (int i = 0; i < NB; i++) dcnt_q[i] <= '0;
      for (int k = 0; k < CH; k++) begin
        sub_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      err_q     <= '0;
      pb_evt_q  <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      sync1_q   <= {pb_i, enc_i};
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      presc_q   <= presc_d;
      for (int i = 0; i < NB; i++) dcnt_q[i] <= dcnt_d[i];
      for (int k = 0; k < CH; k++) begin
        sub_q[k] <= sub_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      err_q     <= err_d;
      pb_evt_q  <= pb_evt_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;
  assign err_o     = err_q;
  assign pb_lvl_o  = ~acc_q[2*CH +: PB];
  assign pb_evt_o  = pb_evt_q;

endmodule

// File: tb/tb_enc_pb_scan.sv
// Scoreboard bench for enc_pb_scan: reads push expected counts, a monitor pops them on rd_vld_o.
module tb_enc_pb_scan;

  localparam int CH = 8;
  localparam int PB = 8;
  localparam int CNT_W = 4;

  logic                    clk, rst;
  logic [2*CH-1:0]         enc_i;
  logic [PB-1:0]           pb_i, pb_clr_i;
  logic                    rd_i;
  logic [3:0]              rd_sel_i;
  logic signed [CNT_W-1:0] rd_data_o;
  logic                    rd_vld_o;
  logic [CH-1:0]           err_o;
  logic [PB-1:0]           pb_lvl_o, pb_evt_o;

  enc_pb_scan #(.CH(CH), .PB(PB), .CNT_W(CNT_W), .DEB_DIV(4), .DEB_CNT(2), .DETENT(4)) dut (
    .clk_i(clk), .rst_i(rst), .enc_i(enc_i), .pb_i(pb_i), .rd_i(rd_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o), .err_o(err_o), .pb_lvl_o(pb_lvl_o),
    .pb_evt_o(pb_evt_o), .pb_clr_i(pb_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the debounce prescaler phase (tick edge ends a cycle with ph==3).
  int ph;
  always @(posedge clk) begin
    if (rst) ph <= 0;
    else     ph <= (ph == 3) ? 0 : ph + 1;
  end

  int checks = 0;
  int failures = 0;
  int expq[$];
  int pos[CH];
  logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rd_vld_o) begin
        if (expq.size() == 0) chk("unexpected_rd_vld", 1, 0);
        else                  chk("rd_data", int'(rd_data_o), expq.pop_front());
      end
    end
  end

  task automatic rd(input int sel, input int exp);
    rd_i = 1'b1;
    rd_sel_i = 4'(sel);
    expq.push_back(exp);
    @(negedge clk);
    rd_i = 1'b0;
  endtask

  task automatic move(input logic [7:0] m, input int dir, input int n);
    for (int e = 0; e < n; e++) begin
      for (int c = 0; c < CH; c++) begin
        if (m[c]) begin
          pos[c] = (pos[c] + dir + 4) % 4;
          enc_i[2*c +: 2] = gray[pos[c]];
        end
      end
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic align();
    do @(negedge clk); while (ph != 3);
  endtask

  initial begin
    rst = 1'b1; enc_i = '1; pb_i = '1; pb_clr_i = '0; rd_i = 1'b0; rd_sel_i = '0;
    for (int c = 0; c < CH; c++) pos[c] = 2;
    repeat (3) @(negedge clk);
    chk("rst_rd_data", int'(rd_data_o), 0);
    chk("rst_rd_vld", rd_vld_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_pb_lvl", pb_lvl_o, 0);
    chk("rst_pb_evt", pb_evt_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Button 0: press lands exactly on the second stable tick, bounces afterwards.
    align();
    pb_i[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("pb0_lvl_before_accept", pb_lvl_o[0], 0);
    @(negedge clk);
    chk("pb0_lvl_accept", pb_lvl_o[0], 1);
    chk("pb0_evt_accept", pb_evt_o[0], 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pb_i[0] = ~pb_i[0];
      repeat (4) @(negedge clk);
      chk("pb0_bounce_lvl", pb_lvl_o[0], 1);
    end
    pb_clr_i[0] = 1'b1;
    @(negedge clk);
    pb_clr_i[0] = 1'b0;
    chk("pb0_evt_cleared", pb_evt_o[0], 0);
    for (int i = 0; i < 4; i++) begin
      pb_i[0] = ~pb_i[0];
      repeat (4) @(negedge clk);
    end
    chk("pb0_evt_once", pb_evt_o[0], 0);
    pb_i[0] = 1'b1;
    repeat (16) @(negedge clk);
    chk("pb0_release", pb_lvl_o[0], 0);

    // Channel 0: 16 CW edges, back-to-back reads, then 8 CCW edges.
    move(8'h01, 1, 16);
    rd(0, 4);
    rd(0, 0);
    move(8'h01, -1, 8);
    rd(0, -2);

    // Channels 1 and 2 saturate at +7; one CCW step on ch1 gives 6.
    move(8'h06, 1, 160);
    rd(2, 7);
    move(8'h02, -1, 4);
    rd(1, 6);

    // Step completes in the same cycle as the read of ch0.
    move(8'h01, 1, 3);
    align();
    pos[0] = (pos[0] + 1) % 4;
    enc_i[1:0] = gray[pos[0]];
    repeat (8) @(negedge clk);
    rd(0, 0);
    rd(0, 1);

    // Channel 3 illegal jump 00 -> 11.
    move(8'h08, 1, 2);
    enc_i[7:6] = 2'b11;
    pos[3] = 2;
    repeat (16) @(negedge clk);
    chk("err3_set", err_o[3], 1);
    chk("err_others_clear", int'(err_o & 8'hF7), 0);
    rd(3, 0);
    chk("err3_cleared_by_read", err_o[3], 0);
    rd(15, 0);

    // Button 2: clear in the same cycle as the press edge.
    align();
    pb_i[2] = 1'b0;
    repeat (8) @(negedge clk);
    pb_clr_i[2] = 1'b1;
    @(negedge clk);
    pb_clr_i[2] = 1'b0;
    chk("pb2_evt_set_wins", pb_evt_o[2], 1);
    chk("pb2_lvl", pb_lvl_o[2], 1);

    // Reset mid-operation with nonzero state and a pending read.
    move(8'h50, 1, 4);
    rd(6, 1);
    enc_i[11:10] = 2'b00;
    pos[5] = 0;
    repeat (16) @(negedge clk);
    chk("err5_set", err_o[5], 1);
    pb_i[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    rd_i = 1'b1;
    rd_sel_i = 4'd4;
    @(negedge clk);
    rst = 1'b0;
    rd_i = 1'b0;
    chk("midrst_rd_vld", rd_vld_o, 0);
    chk("midrst_rd_data", int'(rd_data_o), 0);
    chk("midrst_err", err_o, 0);
    chk("midrst_pb_lvl", pb_lvl_o, 0);
    chk("midrst_pb_evt", pb_evt_o, 0);
    repeat (16) @(negedge clk);
    rd(4, 0);

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    chk("rd_drain", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
